regs: RTL and testbench

// - Register file and I/O register. Sits directly upstream of the ALU.
// - Two combinational read ports drive the ALU a/b operands. One synchronous write port takes back the ALU result.
// - R0 is hard-wired zero. R_IN captures external switch data on a synchronised strobe. R_OUT also drives the LED output.

---
 rtl/regs_pkg.sv | 13 +
 rtl/regs_sync_edge.sv | 24 ++
 rtl/regs.sv | 73 +++++++
 tb/tb_regs.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/regs_pkg.sv
// rtl/regs_pkg.sv - shared types and register indices for the regs register file
package regs_pkg;
    localparam int N      = 8;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 2 ** ADDR_W;

    typedef logic signed [N-1:0] data_t;
    typedef logic [ADDR_W-1:0]   regaddr_t;

    localparam regaddr_t R_ZERO = 3'd0;
    localparam regaddr_t R_IN   = 3'd1;
    localparam regaddr_t R_OUT  = 3'd2;
endpackage

// File: rtl/regs_sync_edge.sv
// rtl/regs_sync_edge.sv - 2-flop synchroniser with rising-edge pulse
module sync_edge (
    input  logic clk,
    input  logic n_reset,
    input  logic async_i,
    output logic rise_o
);
    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // s3_q only delays s2_q for the edge compare; it is not a third sync stage
    assign rise_o = s2_q & ~s3_q;
endmodule

// File: rtl/regs.sv
// rtl/regs.sv - register file with switch-capture and LED registers; REGS_BYPASS_EN enables write-through reads
module regs
    import regs_pkg::*;
(
    input  logic              clk,
    input  logic              n_reset,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [N-1:0]      alu_a,
    output logic [N-1:0]      alu_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [N-1:0]      w_data,
    input  logic [N-1:0]      sw_data,
    input  logic              sw_strobe,
    output logic              in_valid,
    input  logic              in_ack,
    output logic [N-1:0]      leds
);
    data_t       regs_q [NREGS];
    logic [N-1:0] leds_q;
    logic        in_valid_q, in_valid_d;
    logic        cap;
    logic        wr_en;

    sync_edge u_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .async_i (sw_strobe),
        .rise_o  (cap)
    );

    // A capture into R_IN on the same edge suppresses the CPU write there
    assign wr_en = we && (w_addr != R_ZERO) && !(cap && (w_addr == R_IN));

    always_comb begin
        in_valid_d = in_valid_q;
        if (cap)
            in_valid_d = 1'b1;
        else if (in_ack)
            in_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            regs_q     <= '{default: '0};
            leds_q     <= '0;
            in_valid_q <= 1'b0;
        end else begin
            if (wr_en)
                regs_q[w_addr] <= data_t'(w_data);
            if (cap)
                regs_q[R_IN] <= data_t'(sw_data);
            if (wr_en && (w_addr == R_OUT))
                leds_q <= w_data;
            in_valid_q <= in_valid_d;
        end
    end

    always_comb begin
        alu_a = (ra_addr == R_ZERO) ? '0 : regs_q[ra_addr];
        alu_b = (rb_addr == R_ZERO) ? '0 : regs_q[rb_addr];
`ifdef REGS_BYPASS_EN
        if (wr_en && (w_addr == ra_addr))
            alu_a = w_data;
        if (wr_en && (w_addr == rb_addr))
            alu_b = w_data;
`endif
    end

    assign leds     = leds_q;
    assign in_valid = in_valid_q;
endmodule

// File: tb/tb_regs.sv
// tb/tb_regs.sv - directed self-checking bench for regs
module tb_regs;
    logic       clk = 1'b0;
    logic       n_reset;
    logic [2:0] ra_addr, rb_addr, w_addr;
    logic [7:0] alu_a, alu_b, w_data, sw_data, leds;
    logic       we, sw_strobe, in_valid, in_ack;

    int pass_cnt = 0;
    int total_cnt = 0;

    regs dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .ra_addr   (ra_addr),
        .rb_addr   (rb_addr),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .we        (we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .sw_data   (sw_data),
        .sw_strobe (sw_strobe),
        .in_valid  (in_valid),
        .in_ack    (in_ack),
        .leds      (leds)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_reset = 1'b0; we = 1'b0; w_addr = 3'd0; w_data = 8'h00;
        ra_addr = 3'd3; rb_addr = 3'd1; sw_data = 8'h00; sw_strobe = 1'b0; in_ack = 1'b0;
        step(); step();
        total_cnt++;
        if (alu_a !== 8'h00 || alu_b !== 8'h00 || leds !== 8'h00 || in_valid !== 1'b0)
            $display("FAIL reset_init: a=%h b=%h leds=%h iv=%b, want 00 00 00 0", alu_a, alu_b, leds, in_valid);
        else pass_cnt++;
        n_reset = 1'b1;
        step();
        we = 1'b1; w_addr = 3'd3; w_data = 8'h55;
        step();
        w_addr = 3'd2; w_data = 8'h33;
        step();
        we = 1'b0;
        #1;
        total_cnt++;
        if (alu_a !== 8'h55 || leds !== 8'h33)
            $display("FAIL reset_prewrite: a=%h leds=%h, want 55 33", alu_a, leds);
        else pass_cnt++;
        we = 1'b1; w_addr = 3'd3; w_data = 8'h66;
        #2;
        n_reset = 1'b0;
        #1;
        total_cnt++;
        if (alu_a !== 8'h00 || leds !== 8'h00 || in_valid !== 1'b0)
            $display("FAIL reset_async: a=%h leds=%h iv=%b, want 00 00 0", alu_a, leds, in_valid);
        else pass_cnt++;
        step();
        we = 1'b0;
        n_reset = 1'b1;
        step();
        total_cnt++;
        if (alu_a !== 8'h00)
            $display("FAIL reset_hold: a=%h, want 00", alu_a);
        else pass_cnt++;
    endtask

    task automatic test_write_read();
        we = 1'b1; w_addr = 3'd3; w_data = 8'hF4;
        step();
        we = 1'b0; ra_addr = 3'd3; rb_addr = 3'd3;
        #1;
        total_cnt++;
        if (alu_a !== 8'hF4 || alu_b !== 8'hF4)
            $display("FAIL write_read: a=%h b=%h, want F4 F4", alu_a, alu_b);
        else pass_cnt++;
        we = 1'b1; w_addr = 3'd0; w_data = 8'h7F;
        step();
        we = 1'b0; ra_addr = 3'd0; rb_addr = 3'd3;
        #1;
        total_cnt++;
        if (alu_a !== 8'h00 || alu_b !== 8'hF4)
            $display("FAIL r0_write: a=%h b=%h, want 00 F4", alu_a, alu_b);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        logic [7:0] exp_byp;
`ifdef REGS_BYPASS_EN
        exp_byp = 8'h13;
`else
        exp_byp = 8'h00;
`endif
        ra_addr = 3'd4; rb_addr = 3'd0;
        we = 1'b1; w_addr = 3'd4; w_data = 8'h13;
        #1;
        total_cnt++;
        if (alu_a !== exp_byp)
            $display("FAIL bypass_same_cycle: a=%h, want %h", alu_a, exp_byp);
        else pass_cnt++;
        step();
        we = 1'b0;
        #1;
        total_cnt++;
        if (alu_a !== 8'h13)
            $display("FAIL bypass_after_edge: a=%h, want 13", alu_a);
        else pass_cnt++;
        we = 1'b1; w_addr = 3'd0; w_data = 8'hEE;
        #1;
        total_cnt++;
        if (alu_b !== 8'h00)
            $display("FAIL bypass_r0: b=%h, want 00", alu_b);
        else pass_cnt++;
        step();
        we = 1'b0;
    endtask

    task automatic test_capture();
        ra_addr = 3'd1;
        sw_data = 8'h60; sw_strobe = 1'b1;
        step(); step();
        total_cnt++;
        if (in_valid !== 1'b0 || alu_a !== 8'h00)
            $display("FAIL capture_early: iv=%b a=%h, want 0 00", in_valid, alu_a);
        else pass_cnt++;
        step();
        total_cnt++;
        if (in_valid !== 1'b1 || alu_a !== 8'h60)
            $display("FAIL capture_third_edge: iv=%b a=%h, want 1 60", in_valid, alu_a);
        else pass_cnt++;
        sw_data = 8'h08;
        for (int i = 0; i < 10; i++) step();
        total_cnt++;
        if (alu_a !== 8'h60 || in_valid !== 1'b1)
            $display("FAIL capture_held: a=%h iv=%b, want 60 1", alu_a, in_valid);
        else pass_cnt++;
        in_ack = 1'b1;
        step();
        in_ack = 1'b0;
        total_cnt++;
        if (in_valid !== 1'b0)
            $display("FAIL capture_ack: iv=%b, want 0", in_valid);
        else pass_cnt++;
        sw_strobe = 1'b0;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_capture_race();
        ra_addr = 3'd1;
        sw_data = 8'h5A; sw_strobe = 1'b1;
        step(); step();
        we = 1'b1; w_addr = 3'd1; w_data = 8'hAA; in_ack = 1'b1;
        #1;
        total_cnt++;
        if (alu_a !== 8'h60)
            $display("FAIL race_no_bypass: a=%h, want 60", alu_a);
        else pass_cnt++;
        step();
        we = 1'b0;
        total_cnt++;
        if (alu_a !== 8'h5A || in_valid !== 1'b1)
            $display("FAIL race_capture_wins: a=%h iv=%b, want 5A 1", alu_a, in_valid);
        else pass_cnt++;
        step();
        in_ack = 1'b0;
        total_cnt++;
        if (in_valid !== 1'b0)
            $display("FAIL race_ack_next: iv=%b, want 0", in_valid);
        else pass_cnt++;
        in_ack = 1'b1;
        step();
        in_ack = 1'b0;
        total_cnt++;
        if (in_valid !== 1'b0 || alu_a !== 8'h5A)
            $display("FAIL ack_idle: iv=%b a=%h, want 0 5A", in_valid, alu_a);
        else pass_cnt++;
        sw_strobe = 1'b0;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_output();
        we = 1'b1; w_addr = 3'd2; w_data = 8'hFC; ra_addr = 3'd2;
        #1;
        total_cnt++;
        if (leds !== 8'h00)
            $display("FAIL leds_before_edge: leds=%h, want 00", leds);
        else pass_cnt++;
        step();
        we = 1'b0;
        #1;
        total_cnt++;
        if (leds !== 8'hFC || alu_a !== 8'hFC)
            $display("FAIL leds_write: leds=%h a=%h, want FC FC", leds, alu_a);
        else pass_cnt++;
        we = 1'b1; w_addr = 3'd5; w_data = 8'h01;
        step();
        we = 1'b0;
        total_cnt++;
        if (leds !== 8'hFC)
            $display("FAIL leds_other_write: leds=%h, want FC", leds);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_capture();
        test_capture_race();
        test_output();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
